// File: rtl/bridge_pkg.sv
// Shared types and helpers for the host-to-narrow-bus width converter.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    DONE
  } state_t;

  // Default geometry: 32-bit host over a 16-bit bus.
  localparam int unsigned RATIO      = 32 / 16;
  localparam int unsigned LANE_BYTES = 16 / 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p * 2) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bridge_lane_sel.sv
// Priority encoder: lowest lane with nonzero byte enables above (or at) the current lane.
module bridge_lane_sel
  import bridge_pkg::*;
#(
  parameter  int unsigned N_LANES = RATIO,
  parameter  int unsigned LBYTES  = LANE_BYTES,
  localparam int unsigned LW      = clog2(N_LANES)
) (
  input  logic [N_LANES*LBYTES-1:0] bytesel,
  input  logic [LW-1:0]             cur_lane,
  input  logic                      incl_cur,
  output logic [LW-1:0]             next_lane,
  output logic                      next_valid
);

  always_comb begin
    next_lane  = '0;
    next_valid = 1'b0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (!next_valid && (|bytesel[i*LBYTES +: LBYTES]) &&
          ((i > 32'(cur_lane)) || (incl_cur && (i == 32'(cur_lane))))) begin
        next_valid = 1'b1;
        next_lane  = LW'(i);
      end
    end
  end

endmodule

// File: rtl/bridge_width_conv.sv
// Splits one host access into sequential narrow-bus beats, one per enabled lane.
// Optional per-beat timeout enabled by defining BRIDGE_TIMEOUT_EN.
module bridge_width_conv
  import bridge_pkg::*;
#(
  parameter int unsigned H_WIDTH        = 32,
  parameter int unsigned B_WIDTH        = 16,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  h_cs,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [H_WIDTH-1:0]    h_wdata,
  output logic [H_WIDTH-1:0]    h_rdata,
  input  logic                  h_wr_en,
  input  logic [H_WIDTH/8-1:0]  h_bytesel,
  output logic                  h_compl,
  output logic                  h_err,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [B_WIDTH-1:0]    b_wdata,
  input  logic [B_WIDTH-1:0]    b_rdata,
  output logic                  b_wr_en,
  output logic [B_WIDTH/8-1:0]  b_bytesel,
  input  logic                  b_compl
);

  localparam int unsigned N_LANES = H_WIDTH / B_WIDTH;
  localparam int unsigned LB      = B_WIDTH / 8;
  localparam int unsigned HB      = H_WIDTH / 8;
  localparam int unsigned LW      = clog2(N_LANES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(HB - 1);

  state_t                state;
  logic [LW-1:0]         lane;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [H_WIDTH-1:0]    wdata_q;
  logic                  wr_q;
  logic [HB-1:0]         bsel_q;

  logic [LW-1:0]         first_lane, next_lane, ld_lane;
  logic                  first_valid, next_valid;
  logic [ADDR_WIDTH-1:0] src_addr, ld_addr;
  logic [H_WIDTH-1:0]    src_wdata;
  logic [HB-1:0]         src_bsel;
  logic [B_WIDTH-1:0]    ld_wdata;
  logic [LB-1:0]         ld_bsel;

  bridge_lane_sel #(.N_LANES(N_LANES), .LBYTES(LB)) u_first_sel (
    .bytesel    (h_bytesel),
    .cur_lane   ('0),
    .incl_cur   (1'b1),
    .next_lane  (first_lane),
    .next_valid (first_valid)
  );

  bridge_lane_sel #(.N_LANES(N_LANES), .LBYTES(LB)) u_next_sel (
    .bytesel    (bsel_q),
    .cur_lane   (lane),
    .incl_cur   (1'b0),
    .next_lane  (next_lane),
    .next_valid (next_valid)
  );

  // The beat loaded on acceptance comes straight from the host inputs;
  // later beats come from the latched copy.
  always_comb begin
    ld_lane   = (state == IDLE) ? first_lane : next_lane;
    src_addr  = (state == IDLE) ? (h_addr & ALIGN_MASK) : addr_q;
    src_wdata = (state == IDLE) ? h_wdata : wdata_q;
    src_bsel  = (state == IDLE) ? h_bytesel : bsel_q;
    ld_addr   = src_addr + ADDR_WIDTH'(ld_lane) * ADDR_WIDTH'(LB);
    ld_wdata  = src_wdata[ld_lane*B_WIDTH +: B_WIDTH];
    ld_bsel   = src_bsel[ld_lane*LB +: LB];
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;
`else
  assign h_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lane      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      bsel_q    <= '0;
      h_rdata   <= '0;
      h_compl   <= 1'b0;
      b_addr    <= '0;
      b_wdata   <= '0;
      b_wr_en   <= 1'b0;
      b_bytesel <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      h_err     <= 1'b0;
      tcnt      <= '0;
`endif
    end else begin
      h_compl <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      h_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (h_cs && first_valid) begin
            addr_q    <= h_addr & ALIGN_MASK;
            wdata_q   <= h_wdata;
            wr_q      <= h_wr_en;
            bsel_q    <= h_bytesel;
            h_rdata   <= '0;
            lane      <= ld_lane;
            b_addr    <= ld_addr;
            b_wdata   <= ld_wdata;
            b_bytesel <= ld_bsel;
            b_wr_en   <= h_wr_en;
`ifdef BRIDGE_TIMEOUT_EN
            tcnt      <= '0;
`endif
            state     <= REQ;
          end
        end
        REQ: begin
          if (b_compl) begin
            if (!wr_q) h_rdata[lane*B_WIDTH +: B_WIDTH] <= b_rdata;
            b_bytesel <= '0;
            if (next_valid) begin
              state <= GAP;
            end else begin
              state   <= DONE;
              h_compl <= 1'b1;
            end
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            b_bytesel <= '0;
            state     <= DONE;
            h_compl   <= 1'b1;
            h_err     <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end
        GAP: begin
          lane      <= ld_lane;
          b_addr    <= ld_addr;
          b_wdata   <= ld_wdata;
          b_bytesel <= ld_bsel;
`ifdef BRIDGE_TIMEOUT_EN
          tcnt      <= '0;
`endif
          state     <= REQ;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_width_conv.sv
// Bench for bridge_width_conv: a 32/16 and a 64/16 instance against a per-cycle trace model.
module tb_bridge_width_conv;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] h_addr;
  logic [63:0] h_wdata;
  logic        h_wr_en;
  logic [7:0]  h_bytesel;
  logic        cs32, cs64;

  logic [31:0] rdata32;
  logic [63:0] rdata64;
  logic        compl32, compl64, err32, err64;
  logic [31:0] baddr32, baddr64;
  logic [15:0] bwd32, bwd64, brd32, brd64;
  logic        bwr32, bwr64, bc32, bc64;
  logic [1:0]  bbs32, bbs64;

  bridge_width_conv #(.H_WIDTH(32), .B_WIDTH(16), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .h_cs(cs32), .h_addr(h_addr), .h_wdata(h_wdata[31:0]),
    .h_rdata(rdata32), .h_wr_en(h_wr_en), .h_bytesel(h_bytesel[3:0]), .h_compl(compl32),
    .h_err(err32), .b_addr(baddr32), .b_wdata(bwd32), .b_rdata(brd32), .b_wr_en(bwr32),
    .b_bytesel(bbs32), .b_compl(bc32)
  );

  bridge_width_conv #(.H_WIDTH(64), .B_WIDTH(16), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .h_cs(cs64), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(rdata64), .h_wr_en(h_wr_en), .h_bytesel(h_bytesel), .h_compl(compl64),
    .h_err(err64), .b_addr(baddr64), .b_wdata(bwd64), .b_rdata(brd64), .b_wr_en(bwr64),
    .b_bytesel(bbs64), .b_compl(bc64)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned wait_n = 0;
  bit          mute = 1'b0;

  // Slave memory contents are a pure function of the beat address.
  function automatic logic [15:0] rd_word(input logic [31:0] a);
    logic [15:0] k;
    k = 16'(((a >> 1) & 32'd7) + 32'd1);
    return k * 16'h1111;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  initial begin : slave32
    int unsigned cnt;
    cnt = 0; bc32 = 1'b0; brd32 = '0;
    forever begin
      @(negedge clk);
      if (bc32) bc32 = 1'b0;
      else if (bbs32 != 2'b00 && !mute) begin
        if (cnt >= wait_n) begin bc32 = 1'b1; brd32 = rd_word(baddr32); cnt = 0; end
        else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : slave64
    int unsigned cnt;
    cnt = 0; bc64 = 1'b0; brd64 = '0;
    forever begin
      @(negedge clk);
      if (bc64) bc64 = 1'b0;
      else if (bbs64 != 2'b00 && !mute) begin
        if (cnt >= wait_n) begin bc64 = 1'b1; brd64 = rd_word(baddr64); cnt = 0; end
        else cnt++;
      end else cnt = 0;
    end
  end

  typedef struct {
    logic [1:0]  bs;
    logic [31:0] addr;
    logic [15:0] wd;
    bit          compl;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  int          compl_cyc;
  logic [31:0] first_addr;
  logic [15:0] first_wd;
  logic [1:0]  first_bs;
  logic        first_wr;
  logic [63:0] got_rdata;

  // Builds the expected per-cycle trace from the lane list and wait count, then compares every cycle.
  task automatic run_txn(input bit wide, input logic [31:0] addr, input logic [63:0] wd,
                         input bit wr, input logic [7:0] bs, input int unsigned wt, input bit scramble);
    int unsigned nl, cyc, L;
    logic [31:0] base;
    logic [63:0] exp_rd;
    bit          aborted;
    exp_t        e, g;
    logic [1:0]  o_bs;
    logic [31:0] o_addr;
    logic [15:0] o_wd;
    logic        o_wr, o_compl, o_err;
    logic [63:0] o_rd;

    nl = wide ? 4 : 2;
    base = addr & ~(wide ? 32'd7 : 32'd3);
    exp_rd = '0; aborted = 1'b0;
    exp_q.delete();
    wait_n = wt;
    g.bs = 2'b00; g.addr = '0; g.wd = '0; g.compl = 1'b0; g.err = 1'b0;
    for (int unsigned k = 0; k < nl; k++) begin
      if (aborted) break;
      if (bs[k*2 +: 2] == 2'b00) continue;
      if (exp_q.size() != 0) exp_q.push_back(g);
      e.bs = bs[k*2 +: 2]; e.addr = base + 32'(2 * k); e.wd = wd[k*16 +: 16];
      e.compl = 1'b0; e.err = 1'b0;
      cyc = wt + 1;
`ifdef BRIDGE_TIMEOUT_EN
      if (mute || wt >= TO) begin cyc = TO; aborted = 1'b1; end
`endif
      repeat (cyc) exp_q.push_back(e);
      if (!aborted && !wr) exp_rd[k*16 +: 16] = rd_word(base + 32'(2 * k));
    end
    g.compl = 1'b1; g.err = aborted;
    exp_q.push_back(g);
    L = exp_q.size();

    @(negedge clk);
    h_addr = addr; h_wdata = wd; h_wr_en = wr; h_bytesel = bs;
    if (wide) cs64 = 1'b1; else cs32 = 1'b1;
    @(posedge clk);
    compl_cyc = 0; got_rdata = '1;
    for (int unsigned c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      if (wide) begin
        o_bs = bbs64; o_addr = baddr64; o_wd = bwd64; o_wr = bwr64;
        o_compl = compl64; o_err = err64; o_rd = rdata64;
      end else begin
        o_bs = bbs32; o_addr = baddr32; o_wd = bwd32; o_wr = bwr32;
        o_compl = compl32; o_err = err32; o_rd = {32'h0, rdata32};
      end
      if (c <= L) begin
        e = exp_q[c-1];
        check($sformatf("b_bytesel@%0d", c), 64'(o_bs), 64'(e.bs));
        if (e.bs != 2'b00) begin
          check($sformatf("b_addr@%0d", c), 64'(o_addr), 64'(e.addr));
          check($sformatf("b_wr_en@%0d", c), 64'(o_wr), 64'(wr));
          if (wr) check($sformatf("b_wdata@%0d", c), 64'(o_wd), 64'(e.wd));
        end
        check($sformatf("h_compl@%0d", c), 64'(o_compl), 64'(e.compl));
        check($sformatf("h_err@%0d", c), 64'(o_err & o_compl), 64'(e.err));
        if (e.compl) check($sformatf("h_rdata@%0d", c), o_rd, exp_rd);
      end else begin
        check("post_bytesel", 64'(o_bs), 64'd0);
        check("post_compl", 64'(o_compl), 64'd0);
      end
      if (c == 1) begin first_addr = o_addr; first_wd = o_wd; first_bs = o_bs; first_wr = o_wr; end
      if (o_compl && compl_cyc == 0) begin compl_cyc = int'(c); got_rdata = o_rd; end
      if (scramble && c <= L) begin
        if (wide) cs64 = c[0]; else cs32 = c[0];
        h_addr = $urandom; h_wdata = {$urandom, $urandom}; h_wr_en = ~wr; h_bytesel = 8'($urandom);
      end else begin
        cs32 = 1'b0; cs64 = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cs32 = 1'b0; cs64 = 1'b0; h_addr = '0; h_wdata = '0; h_wr_en = 1'b0; h_bytesel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bs32", 64'(bbs32), 64'd0);
    check("rst_compl32", 64'(compl32), 64'd0);
    check("rst_rdata32", 64'(rdata32), 64'd0);
    check("rst_addr32", 64'(baddr32), 64'd0);
    check("rst_bs64", 64'(bbs64), 64'd0);
    check("rst_rdata64", rdata64, 64'd0);
    rst_n = 1'b1;

    run_txn(1'b0, 32'h1000, 64'h0, 1'b0, 8'h0F, 0, 1'b0);
    check("t1_rdata", got_rdata, 64'h2222_1111);
    check("t1_cycle", 64'(compl_cyc), 64'd4);
    check("t1_addr0", 64'(first_addr), 64'h1000);

    run_txn(1'b0, 32'h1000, 64'hABCD_1234, 1'b1, 8'h0C, 0, 1'b0);
    check("t2_addr", 64'(first_addr), 64'h1002);
    check("t2_wdata", 64'(first_wd), 64'hABCD);
    check("t2_bs", 64'(first_bs), 64'h3);
    check("t2_wr", 64'(first_wr), 64'h1);
    check("t2_cycle", 64'(compl_cyc), 64'd2);
    check("t2_rdata", got_rdata, 64'h0);

    run_txn(1'b1, 32'h2000, 64'h0, 1'b0, 8'h30, 0, 1'b0);
    check("t3_addr", 64'(first_addr), 64'h2004);
    check("t3_rdata", got_rdata, 64'h0000_3333_0000_0000);
    check("t3_cycle", 64'(compl_cyc), 64'd2);

    run_txn(1'b0, 32'h3006, 64'h0, 1'b0, 8'h0F, 3, 1'b1);
    check("t4_cycle", 64'(compl_cyc), 64'd10);
    check("t4_rdata", got_rdata, 64'h4444_3333);
    check("t4_addr0", 64'(first_addr), 64'h3004);

    run_txn(1'b0, 32'h0010, 64'h0, 1'b0, 8'h02, 0, 1'b0);
    check("t5_bs", 64'(first_bs), 64'h2);
    check("t5_rdata", got_rdata, 64'h1111);

    run_txn(1'b1, 32'h0040, 64'h0, 1'b0, 8'h81, 0, 1'b0);
    check("t6_cycle", 64'(compl_cyc), 64'd4);
    check("t6_rdata", got_rdata, 64'h4444_0000_0000_1111);

    run_txn(1'b1, 32'h0080, 64'h8877_6655_4433_2211, 1'b1, 8'hFF, 1, 1'b0);
    check("t7_cycle", 64'(compl_cyc), 64'd12);
    check("t7_wdata0", 64'(first_wd), 64'h2211);

    // h_cs with all enables clear must not start an access.
    @(negedge clk);
    cs32 = 1'b1; h_bytesel = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("zero_bs", 64'(bbs32), 64'd0);
      check("zero_compl", 64'(compl32), 64'd0);
    end
    cs32 = 1'b0;

    // Reset while lane 1 is in flight.
    wait_n = 3;
    @(negedge clk);
    h_addr = 32'h500; h_wr_en = 1'b0; h_bytesel = 8'h0F; cs32 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      cs32 = 1'b0;
    end
    check("rst_pre_bs", 64'(bbs32), 64'h3);
    check("rst_pre_addr", 64'(baddr32), 64'h502);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_bs", 64'(bbs32), 64'd0);
    check("rst_mid_compl", 64'(compl32), 64'd0);
    check("rst_mid_rdata", 64'(rdata32), 64'd0);
    check("rst_mid_addr", 64'(baddr32), 64'd0);
    check("rst_mid_wr", 64'(bwr32), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_quiet_compl", 64'(compl32), 64'd0);
      check("rst_quiet_bs", 64'(bbs32), 64'd0);
    end
    run_txn(1'b0, 32'h0500, 64'h0, 1'b0, 8'h0F, 0, 1'b0);
    check("t8_rdata", got_rdata, 64'h2222_1111);
    check("t8_cycle", 64'(compl_cyc), 64'd4);

`ifdef BRIDGE_TIMEOUT_EN
    mute = 1'b1;
    run_txn(1'b0, 32'h0600, 64'h0, 1'b0, 8'h0F, 0, 1'b0);
    mute = 1'b0;
    check("to_cycle", 64'(compl_cyc), 64'd9);
    check("to_rdata", got_rdata, 64'h0);
    run_txn(1'b0, 32'h0600, 64'h0, 1'b0, 8'h0F, TO - 1, 1'b0);
    check("tie_cycle", 64'(compl_cyc), 64'd18);
    check("tie_rdata", got_rdata, 64'h2222_1111);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bridge_width_conv.md
# bridge_width_conv

Parametrised host-to-narrow-bus width converter: splits one H_WIDTH-bit host access into up to RATIO = H_WIDTH/B_WIDTH sequential B_WIDTH-bit beats. Only lanes with nonzero byte enables are issued. The host request is latched at acceptance and all bus-side outputs are registered. It sits between a CPU/data-bus master and narrower memory controllers (e.g. a 16-bit SDRAM controller). An optional per-beat timeout reports a stalled slave to the host.

## Interface
- H_WIDTH, 32: host data width; multiple of 8.
- B_WIDTH, 16: bus data width; multiple of 8; H_WIDTH/B_WIDTH is a power of 2 in 2..8.
- ADDR_WIDTH, 32: address width, both sides.
- TIMEOUT_CYCLES, 256: beat timeout; used only with BRIDGE_TIMEOUT_EN; ≥2.
- clk  in  1  sole clock; everything on posedge.
- rst_n  in  1  **synchronous, active-low** reset.
- h_cs  in  1  host select.
- h_addr  in  ADDR_WIDTH  host byte address; low log2(H_WIDTH/8) bits ignored.
- h_wdata  in  H_WIDTH  write data.
- h_rdata  out  H_WIDTH  read data, valid while h_compl=1.
- h_wr_en  in  1  1 = write.
- h_bytesel  in  H_WIDTH/8  byte enables; nonzero with h_cs starts an access.
- h_compl  out  1  one-cycle completion pulse.
- h_err  out  1  timeout flag, qualified by h_compl; constant 0 without the macro.
- b_addr  out  ADDR_WIDTH  beat byte address.
- b_wdata  out  B_WIDTH  beat write data.
- b_rdata  in  B_WIDTH  beat read data, sampled with b_compl.
- b_wr_en  out  1  beat direction.
- b_bytesel  out  B_WIDTH/8  beat byte enables; nonzero = request active.
- b_compl  in  1  slave completion, one cycle.

## Operation
- States: IDLE, REQ, GAP, DONE.
- IDLE: when h_cs && |h_bytesel:
  - latch h_addr, h_wdata, h_wr_en, h_bytesel; clear h_rdata;
  - select the lowest lane with nonzero enables; go to REQ.
- Lane k byte offset = k*(B_WIDTH/8).
  - b_addr = {aligned h_addr, lane offset}.
  - b_wdata = latched h_wdata[k*B_WIDTH +: B_WIDTH].
  - b_bytesel = latched enable slice of lane k.
- REQ: b_* held stable until b_compl.
  - On b_compl of a read: write b_rdata into h_rdata lane k.
  - Next state is GAP if a higher lane has nonzero enables, else DONE.
- GAP: one cycle, b_bytesel=0; then load the next nonzero lane and go to REQ.
- DONE: h_compl=1 for one cycle; then IDLE.
- Skipped lanes and lanes never fetched read as zero. Write accesses leave h_rdata at zero.
- Host inputs are ignored from acceptance until IDLE is re-entered. A new request is accepted no earlier than the cycle after h_compl.
- b_compl outside REQ is ignored.
- Reset (rst_n=0 at an edge), at any state:
  - state→IDLE; h_compl, h_err, b_bytesel, b_wr_en → 0; h_rdata, b_addr, b_wdata → 0.
  - An in-flight slave beat is abandoned.

## Timing
- All outputs are registered.
- Zero-wait slave (b_compl in the first REQ cycle), accept at edge 0:
  - 32/16, both lanes: REQ in cycle 1, GAP in cycle 2, REQ in cycle 3, h_compl in cycle 4.
  - Single lane: h_compl in cycle 2.
- Total latency = 1 + Σ(beat wait + 1) + (number of beats − 1) gap cycles.
- b_bytesel is always 0 for at least one cycle between beats.

## Configuration
- BRIDGE_TIMEOUT_EN defined:
  - A counter clears on REQ entry and increments each REQ cycle without b_compl.
  - At TIMEOUT_CYCLES the access aborts: b_bytesel←0, go to DONE, h_err=1 with h_compl.
  - Lanes not yet fetched read as zero.
  - b_compl arriving in the same cycle as expiry takes priority (beat succeeds).
- Undefined: no counter; h_err is tied 0; REQ waits indefinitely.

## Structure
- Package bridge_pkg holds:
  - state enum (IDLE/REQ/GAP/DONE);
  - RATIO and lane-byte-count localparams;
  - function clog2.
- Sub-module bridge_lane_sel:
  - combinational priority encoder;
  - inputs: latched bytesel and current lane;
  - outputs: next nonzero lane index above current, plus valid.

## Test plan
- 32/16 read, h_bytesel=4'hF, addr 0x1000, slave returns 0x1111 then 0x2222 with no waits → b_addr 0x1000 then 0x1002; h_rdata=0x22221111; h_compl in cycle 4.
- 32/16 write, h_bytesel=4'hC, wdata 0xABCD1234 → a single beat: b_addr 0x1002, b_wdata 0xABCD, b_bytesel 2'b11, b_wr_en=1; h_compl in cycle 2.
- 64/16 read, h_bytesel=8'h30 → exactly one beat at lane 2 (offset 4); h_rdata=0x0000_XXXX_0000_0000 with the returned word in bits 47:32.
- Slave waits 3 cycles per beat; h_cs changed mid-access → latched request used throughout; b_* stable during waits; h_compl at cycle 10.
- rst_n=0 during REQ of lane 1 → next cycle b_bytesel=0, state IDLE, h_compl never pulses; a new request is accepted normally afterwards.
- BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave silent → h_compl and h_err=1 eight cycles after REQ entry; h_rdata=0.
